mem_wb_skid: RTL and testbench

- Parametrised successor of the MEM/WB stage register. It carries the full write-back bundle from the memory stage to write-back: GPR result, HI/LO, and LLbit.
- The fixed stall-vector scheme is replaced by a valid/ready elastic handshake.
- A 2-entry skid buffer keeps in_ready registered.
- Adds synchronous flush for exceptions, valid-qualified side-effect enables, and a saturating bubble counter for performance monitoring.

---
 rtl/mem_wb_skid.sv | 137 +++++++++++++
 tb/tb_mem_wb_skid.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_skid
// Purpose  : MEM/WB stage register with a valid/ready elastic handshake.
//            Carries the write-back bundle (GPR result, HI/LO, LLbit) from
//            the memory stage to write-back through a 2-entry skid buffer
//            so in_ready is a registered signal. Supports a synchronous
//            flush, valid-qualified side-effect enables and a saturating
//            bubble counter.
// Ports    : clk, rst (async, active high), flush (sync)
//            in_*   : MEM-side beat (valid/ready + payload)
//            out_*  : WB-side beat (valid/ready + payload, gated enables)
//            occupancy  : entries held (0..2)
//            bubble_cnt : cycles with out_ready=1 and out_valid=0
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_skid #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_result,
    input  logic               in_wb_en,
    input  logic [RADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]  in_hi,
    input  logic [DATA_W-1:0]  in_lo,
    input  logic               in_hilo_en,
    input  logic               in_llbit_en,
    input  logic               in_llbit_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic               out_wb_en,
    output logic [RADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]  out_hi,
    output logic [DATA_W-1:0]  out_lo,
    output logic               out_hilo_en,
    output logic               out_llbit_en,
    output logic               out_llbit_data,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int c_PAY_W = 3*DATA_W + RADDR_W + 4;

    // Storage: head drives the outputs, skid absorbs one beat of backpressure.
    logic               r_head_valid;
    logic [c_PAY_W-1:0] r_head_pay;
    logic               r_skid_valid;
    logic [c_PAY_W-1:0] r_skid_pay;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic [c_PAY_W-1:0] w_in_pay;
    logic               w_accept;
    logic               w_pop;

    // Head-payload fields
    logic [DATA_W-1:0]  w_h_result;
    logic               w_h_wb_en;
    logic [RADDR_W-1:0] w_h_dest;
    logic [DATA_W-1:0]  w_h_hi;
    logic [DATA_W-1:0]  w_h_lo;
    logic               w_h_hilo_en;
    logic               w_h_llbit_en;
    logic               w_h_llbit_data;

    assign w_in_pay = {in_result, in_wb_en, in_dest, in_hi, in_lo,
                       in_hilo_en, in_llbit_en, in_llbit_data};

    assign {w_h_result, w_h_wb_en, w_h_dest, w_h_hi, w_h_lo,
            w_h_hilo_en, w_h_llbit_en, w_h_llbit_data} = r_head_pay;

    // Ready depends only on skid state, never on out_ready, so the
    // upstream timing path is cut at this register.
    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = r_head_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_head_pay   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pay   <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // Bubble counter keeps running through flushes; only rst clears it.
            if (out_ready && !r_head_valid && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end

            if (flush) begin
                // Payload registers are left alone; only validity is dropped.
                r_head_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_head_valid || w_pop) begin
                if (r_skid_valid) begin
                    // Skid beat is older than anything at the input, and
                    // in_ready is low while it is full, so no accept here.
                    r_head_pay   <= r_skid_pay;
                    r_head_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_head_pay   <= w_in_pay;
                    r_head_valid <= 1'b1;
                end else begin
                    r_head_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_pay   <= w_in_pay;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid      = r_head_valid;
    assign out_result     = w_h_result;
    assign out_dest       = w_h_dest;
    assign out_hi         = w_h_hi;
    assign out_lo         = w_h_lo;
    assign out_llbit_data = w_h_llbit_data;

    // Side-effect enables are qualified so WB never commits a stale payload.
    assign out_wb_en      = w_h_wb_en    && r_head_valid;
    assign out_hilo_en    = w_h_hilo_en  && r_head_valid;
    assign out_llbit_en   = w_h_llbit_en && r_head_valid;

    assign occupancy  = {1'b0, r_head_valid} + {1'b0, r_skid_valid};
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_skid
// Purpose  : Self-checking bench for mem_wb_skid. Stimulus pushes expected
//            beats into a queue when they are accepted; a monitor pops and
//            compares each beat the DUT hands to WB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid;

    typedef struct packed {
        logic [31:0] result;
        logic        wb_en;
        logic [4:0]  dest;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hilo_en;
        logic        llbit_en;
        logic        llbit_data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    beat_t       in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_wb_en;
    logic [4:0]  out_dest;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_hilo_en;
    logic        out_llbit_en;
    logic        out_llbit_data;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    // Narrow-counter instance: idle, always ready, for saturation.
    logic        s_in_ready, s_out_valid, s_wb_en, s_hilo_en, s_llbit_en, s_lld;
    logic [31:0] s_result, s_hi, s_lo;
    logic [4:0]  s_dest;
    logic [1:0]  s_occ;
    logic [3:0]  s_bubble;

    int    total = 0;
    int    passed = 0;
    int    popped = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    mem_wb_skid #(.DATA_W(32), .RADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_b.result), .in_wb_en(in_b.wb_en), .in_dest(in_b.dest),
        .in_hi(in_b.hi), .in_lo(in_b.lo), .in_hilo_en(in_b.hilo_en),
        .in_llbit_en(in_b.llbit_en), .in_llbit_data(in_b.llbit_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_wb_en(out_wb_en), .out_dest(out_dest),
        .out_hi(out_hi), .out_lo(out_lo), .out_hilo_en(out_hilo_en),
        .out_llbit_en(out_llbit_en), .out_llbit_data(out_llbit_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    mem_wb_skid #(.DATA_W(32), .RADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(1'b0), .in_ready(s_in_ready),
        .in_result(32'd0), .in_wb_en(1'b0), .in_dest(5'd0),
        .in_hi(32'd0), .in_lo(32'd0), .in_hilo_en(1'b0),
        .in_llbit_en(1'b0), .in_llbit_data(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_result(s_result), .out_wb_en(s_wb_en), .out_dest(s_dest),
        .out_hi(s_hi), .out_lo(s_lo), .out_hilo_en(s_hilo_en),
        .out_llbit_en(s_llbit_en), .out_llbit_data(s_lld),
        .occupancy(s_occ), .bubble_cnt(s_bubble)
    );

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {127'd0, out_valid}, 128'd0);
            end else begin
                check("beat", {23'd0, out_result, out_wb_en, out_dest, out_hi,
                               out_lo, out_hilo_en, out_llbit_en, out_llbit_data},
                      {23'd0, exp_q[0]});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end else begin
            check("idle_enables", {125'd0, out_wb_en, out_hilo_en, out_llbit_en}, 128'd0);
        end
    end

    // Present a beat until accepted (bounded); called at posedge+1.
    task automatic send(input beat_t b, output int waited);
        logic acc;
        in_b     = b;
        in_valid = 1'b1;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 20) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            if (acc) exp_q.push_back(b);
            waited++;
            #1;
        end
        if (!acc) check("send_timeout", {127'd0, acc}, 128'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic beat_t mk(input logic [31:0] r, input logic [4:0] d,
                                 input logic wb, input logic hl, input logic ll);
        beat_t b;
        b.result = r; b.wb_en = wb; b.dest = d;
        b.hi = r ^ 32'hFFFF_0000; b.lo = r + 32'h100;
        b.hilo_en = hl; b.llbit_en = ll; b.llbit_data = r[0];
        return b;
    endfunction

    initial begin
        int w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_occ", {126'd0, occupancy}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_bubble", {112'd0, bubble_cnt}, 128'd0);
        check("rst_result", {96'd0, out_result}, 128'd0);
        rst = 1'b0;

        // Bubble counting from reset, and saturation on the 4-bit instance
        idle(10);
        check("bubble_10", {112'd0, bubble_cnt}, 128'd10);
        check("bubble4_10", {124'd0, s_bubble}, 128'd10);
        idle(10);
        check("bubble4_sat", {124'd0, s_bubble}, 128'd15);

        // Single beat, latency 1
        send(mk(32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0), w);
        check("single_valid", {127'd0, out_valid}, 128'd1);
        check("single_wb_en", {127'd0, out_wb_en}, 128'd1);
        check("single_dest", {123'd0, out_dest}, 128'd5);
        check("single_result", {96'd0, out_result}, 128'h1234_5678);
        idle(1);
        check("single_gone_valid", {127'd0, out_valid}, 128'd0);
        check("single_gone_wb_en", {127'd0, out_wb_en}, 128'd0);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            send(mk(i, i[4:0], 1'b1, 1'b0, 1'b0), w);
            check("stream_no_stall", w, 128'd1);
            check("stream_valid", {127'd0, out_valid}, 128'd1);
            check("stream_result", {96'd0, out_result}, i);
            check("stream_occ_le1", {127'd0, occupancy <= 2'd1}, 128'd1);
        end
        idle(2);

        // Backpressure: A to head, B to skid, C held
        out_ready = 1'b0;
        send(mk(32'hA, 5'd1, 1'b1, 1'b0, 1'b0), w);
        send(mk(32'hB, 5'd2, 1'b1, 1'b0, 1'b0), w);
        check("bp_occ2", {126'd0, occupancy}, 128'd2);
        check("bp_in_ready", {127'd0, in_ready}, 128'd0);
        in_b = mk(32'hC, 5'd3, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        idle(2);
        check("bp_c_held", {126'd0, occupancy}, 128'd2);
        check("bp_head_a", {96'd0, out_result}, 128'hA);
        out_ready = 1'b1;
        send(mk(32'hC, 5'd3, 1'b1, 1'b0, 1'b0), w);
        check("bp_c_wait", w, 128'd2);
        idle(4);
        check("bp_drained", exp_q.size(), 128'd0);

        // Flush with both entries full
        out_ready = 1'b0;
        send(mk(32'h11, 5'd7, 1'b1, 1'b1, 1'b0), w);
        send(mk(32'h22, 5'd8, 1'b1, 1'b0, 1'b1), w);
        check("fl_occ2", {126'd0, occupancy}, 128'd2);
        flush = 1'b1; in_valid = 1'b1; in_b = mk(32'hDEAD, 5'd9, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_occ0", {126'd0, occupancy}, 128'd0);
        check("fl_valid", {127'd0, out_valid}, 128'd0);
        check("fl_hilo_en", {127'd0, out_hilo_en}, 128'd0);
        out_ready = 1'b1;
        idle(3);

        // Flush with room at the input and a simultaneous pop
        out_ready = 1'b0;
        send(mk(32'h33, 5'd10, 1'b1, 1'b1, 1'b1), w);
        check("fl2_occ1", {126'd0, occupancy}, 128'd1);
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
        in_b = mk(32'hBEEF, 5'd11, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        exp_q.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl2_occ0", {126'd0, occupancy}, 128'd0);
        check("fl2_in_ready", {127'd0, in_ready}, 128'd1);
        idle(3);

        // Asynchronous reset mid-cycle with both entries full
        out_ready = 1'b0;
        send(mk(32'h44, 5'd12, 1'b1, 1'b1, 1'b1), w);
        send(mk(32'h55, 5'd13, 1'b1, 1'b1, 1'b1), w);
        check("ar_occ2", {126'd0, occupancy}, 128'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {127'd0, out_valid}, 128'd0);
        check("ar_occ", {126'd0, occupancy}, 128'd0);
        check("ar_enables", {125'd0, out_wb_en, out_hilo_en, out_llbit_en}, 128'd0);
        check("ar_in_ready", {127'd0, in_ready}, 128'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("ar_after_occ", {126'd0, occupancy}, 128'd0);
        check("beats_popped", popped, 128'd13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
